// File: rtl/pipeline_adder_arbiter_pkg.sv
// Shared defaults and helpers for the pipelined-adder arbiter slice.
package pipeline_adder_arbiter_pkg;

   localparam int DEF_N_REQ   = 4;
   localparam int DEF_WIDTH   = 64;
   localparam int DEF_ADD_LAT = 2;

   // A single requester still needs a 1-bit ID field.
   function automatic int id_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/pipeline_adder_arbiter_if.sv
// Requester, adder and response signals of the arbiter, with DUT (slave) and
// environment (master) views.
interface pipeline_adder_arbiter_if
   import pipeline_adder_arbiter_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int WIDTH = DEF_WIDTH,
   parameter int ID_W  = id_width(N_REQ)
);

   logic [N_REQ-1:0]       req_valid;
   logic [N_REQ-1:0]       req_ready;
   logic [N_REQ*WIDTH-1:0] req_a;
   logic [N_REQ*WIDTH-1:0] req_b;
   logic [N_REQ-1:0]       req_cin;

   logic [WIDTH-1:0]       add_a;
   logic [WIDTH-1:0]       add_b;
   logic                   add_cin;
   logic [WIDTH-1:0]       add_sum;
   logic                   add_cout;

   logic                   rsp_valid;
   logic [ID_W-1:0]        rsp_id;
   logic [WIDTH-1:0]       rsp_sum;
   logic                   rsp_cout;
   logic                   busy;

   modport slave (
      input  req_valid, req_a, req_b, req_cin, add_sum, add_cout,
      output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
   );

   modport master (
      output req_valid, req_a, req_b, req_cin, add_sum, add_cout,
      input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
   );

endinterface

// File: rtl/pipeline_adder_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant searching upward from ptr, pointer moves
// past the winner only when the grant is taken.
module rr_arbiter
   import pipeline_adder_arbiter_pkg::*;
#(
   parameter int N_REQ = DEF_N_REQ,
   parameter int ID_W  = id_width(N_REQ)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N_REQ-1:0] req,
   input  logic             advance,
   output logic [N_REQ-1:0] gnt,
   output logic [ID_W-1:0]  gnt_idx
);

   logic [ID_W-1:0] ptr_q, ptr_d;
   logic            found;

   // Two passes emulate the wrap-around: indices at/above ptr first, then below it.
   always_comb begin
      gnt     = '0;
      gnt_idx = '0;
      found   = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[i] && (ID_W'(i) >= ptr_q)) begin
            found   = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = ID_W'(i);
         end
      end
      for (int i = 0; i < N_REQ; i++) begin
         if (!found && req[i] && (ID_W'(i) < ptr_q)) begin
            found   = 1'b1;
            gnt[i]  = 1'b1;
            gnt_idx = ID_W'(i);
         end
      end
   end

   always_comb begin
      ptr_d = ptr_q;
      if (advance) begin
         ptr_d = (gnt_idx == ID_W'(N_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) ptr_q <= '0;
      else        ptr_q <= ptr_d;
   end

endmodule

// File: rtl/pipeline_adder_arbiter.sv
// Shares one external pipelined adder among N_REQ requesters; the requester ID
// rides a tag pipe alongside the adder so each result returns tagged.
module pipeline_adder_arbiter
   import pipeline_adder_arbiter_pkg::*;
#(
   parameter int N_REQ   = DEF_N_REQ,
   parameter int WIDTH   = DEF_WIDTH,
   parameter int ADD_LAT = DEF_ADD_LAT
) (
   input logic                     clk,
   input logic                     rst_n,
   pipeline_adder_arbiter_if.slave bus
);

   localparam int ID_W = id_width(N_REQ);

   logic [N_REQ-1:0] gnt;
   logic [N_REQ-1:0] ready;
   logic [ID_W-1:0]  gnt_idx;
   logic             hs;

   logic [WIDTH-1:0]              add_a_q, add_a_d;
   logic [WIDTH-1:0]              add_b_q, add_b_d;
   logic                          add_cin_q, add_cin_d;
   logic [ADD_LAT:0]              tag_vld_q, tag_vld_d;
   logic [ADD_LAT:0][ID_W-1:0]    tag_id_q, tag_id_d;
   logic                          rsp_valid_q, rsp_valid_d;
   logic [ID_W-1:0]               rsp_id_q, rsp_id_d;
   logic [WIDTH-1:0]              rsp_sum_q, rsp_sum_d;
   logic                          rsp_cout_q, rsp_cout_d;

   rr_arbiter #(.N_REQ(N_REQ), .ID_W(ID_W)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (bus.req_valid),
      .advance (hs),
      .gnt     (gnt),
      .gnt_idx (gnt_idx)
   );

   // No grants are offered while reset is held.
   assign ready = gnt & {N_REQ{rst_n}};
   assign hs    = |(bus.req_valid & ready);

   always_comb begin
      add_a_d   = '0;
      add_b_d   = '0;
      add_cin_d = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         if (hs && gnt[i]) begin
            add_a_d   = bus.req_a[i*WIDTH +: WIDTH];
            add_b_d   = bus.req_b[i*WIDTH +: WIDTH];
            add_cin_d = bus.req_cin[i];
         end
      end
   end

   // Stage 0 shares the edge with the issue registers; stage ADD_LAT meets add_sum.
   always_comb begin
      tag_vld_d = {tag_vld_q[ADD_LAT-1:0], hs};
      tag_id_d  = {tag_id_q[ADD_LAT-1:0], (hs ? gnt_idx : ID_W'(0))};
   end

   always_comb begin
      rsp_valid_d = tag_vld_q[ADD_LAT];
      rsp_id_d    = rsp_id_q;
      rsp_sum_d   = rsp_sum_q;
      rsp_cout_d  = rsp_cout_q;
      if (tag_vld_q[ADD_LAT]) begin
         rsp_id_d   = tag_id_q[ADD_LAT];
         rsp_sum_d  = bus.add_sum;
         rsp_cout_d = bus.add_cout;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         add_a_q     <= '0;
         add_b_q     <= '0;
         add_cin_q   <= 1'b0;
         tag_vld_q   <= '0;
         tag_id_q    <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= '0;
         rsp_sum_q   <= '0;
         rsp_cout_q  <= 1'b0;
      end else begin
         add_a_q     <= add_a_d;
         add_b_q     <= add_b_d;
         add_cin_q   <= add_cin_d;
         tag_vld_q   <= tag_vld_d;
         tag_id_q    <= tag_id_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_sum_q   <= rsp_sum_d;
         rsp_cout_q  <= rsp_cout_d;
      end
   end

   assign bus.req_ready = ready;
   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;
   assign bus.add_cin   = add_cin_q;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_id    = rsp_id_q;
   assign bus.rsp_sum   = rsp_sum_q;
   assign bus.rsp_cout  = rsp_cout_q;
   assign bus.busy      = |tag_vld_q;

endmodule

// File: tb/tb_pipeline_adder_arbiter.sv
// Directed bench for pipeline_adder_arbiter with a behavioural 2-cycle adder
// standing in for the external carry-select adder.
module tb_pipeline_adder_arbiter;

   localparam int N_REQ   = 4;
   localparam int WIDTH   = 64;
   localparam int ADD_LAT = 2;

   logic clk;
   logic rst_n;
   int   n_tests;
   int   n_fail;

   pipeline_adder_arbiter_if #(.N_REQ(N_REQ), .WIDTH(WIDTH)) bus ();

   pipeline_adder_arbiter #(.N_REQ(N_REQ), .WIDTH(WIDTH), .ADD_LAT(ADD_LAT)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // External adder model: ADD_LAT register stages from add_* to add_sum/add_cout.
   logic [WIDTH:0] add_pipe [ADD_LAT];
   always_ff @(posedge clk) begin
      add_pipe[0] <= {1'b0, bus.add_a} + {1'b0, bus.add_b} + {{WIDTH{1'b0}}, bus.add_cin};
      for (int k = 1; k < ADD_LAT; k++) add_pipe[k] <= add_pipe[k-1];
   end
   assign {bus.add_cout, bus.add_sum} = add_pipe[ADD_LAT-1];

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      bus.req_valid = '0;
      tick();
      rst_n = 1'b1;
   endtask

   task automatic set_ops(input int i, input logic [63:0] a, input logic [63:0] b, input logic c);
      bus.req_a[i*WIDTH +: WIDTH] = a;
      bus.req_b[i*WIDTH +: WIDTH] = b;
      bus.req_cin[i]              = c;
   endtask

   // One isolated operation from requester i, checked edge by edge.
   task automatic single_op(input string tag, input int i, input logic [63:0] a, input logic [63:0] b,
                            input logic c, input logic [63:0] es, input logic ec);
      logic [3:0] onehot;
      onehot = 4'b0001 << i;
      set_ops(i, a, b, c);
      bus.req_valid = onehot;
      #1;
      check({tag, "_ready"}, bus.req_ready, onehot);
      tick();
      bus.req_valid = '0;
      set_ops(i, ~a, ~b, ~c);
      check({tag, "_add_a"}, bus.add_a, a);
      check({tag, "_add_b"}, bus.add_b, b);
      check({tag, "_add_cin"}, bus.add_cin, c);
      check({tag, "_busy"}, bus.busy, 1'b1);
      tick();
      check({tag, "_early1"}, bus.rsp_valid, 1'b0);
      tick();
      check({tag, "_early2"}, bus.rsp_valid, 1'b0);
      tick();
      check({tag, "_rsp_valid"}, bus.rsp_valid, 1'b1);
      check({tag, "_rsp_id"}, bus.rsp_id, i);
      check({tag, "_rsp_sum"}, bus.rsp_sum, es);
      check({tag, "_rsp_cout"}, bus.rsp_cout, ec);
      tick();
      check({tag, "_pulse"}, bus.rsp_valid, 1'b0);
      check({tag, "_sum_hold"}, bus.rsp_sum, es);
      check({tag, "_idle"}, bus.busy, 1'b0);
   endtask

   logic [3:0]  exp_gnt3 [6] = '{4'b0001, 4'b0010, 4'b0100, 4'b0001, 4'b0010, 4'b0100};
   logic [63:0] exp_sum3 [6] = '{64'd3, 64'd30, 64'd300, 64'd3, 64'd30, 64'd300};
   int          exp_id3  [6] = '{0, 1, 2, 0, 1, 2};
   logic [3:0]  exp_gnt5 [3] = '{4'b0010, 4'b0100, 4'b0010};
   logic [3:0]  exp_gnt6 [3] = '{4'b1000, 4'b0010, 4'b1000};
   int          exp_id6  [3] = '{3, 1, 3};
   logic [63:0] exp_sum6 [3] = '{64'd77, 64'd33, 64'd77};

   initial begin
      n_tests       = 0;
      n_fail        = 0;
      rst_n         = 1'b0;
      bus.req_valid = '1;
      bus.req_a     = '0;
      bus.req_b     = '0;
      bus.req_cin   = '0;

      // Reset values, and no grants while in reset
      tick();
      tick();
      check("rst_ready", bus.req_ready, 4'b0000);
      check("rst_add_a", bus.add_a, 64'd0);
      check("rst_add_b", bus.add_b, 64'd0);
      check("rst_add_cin", bus.add_cin, 1'b0);
      check("rst_rsp_valid", bus.rsp_valid, 1'b0);
      check("rst_rsp_id", bus.rsp_id, 2'd0);
      check("rst_rsp_sum", bus.rsp_sum, 64'd0);
      check("rst_rsp_cout", bus.rsp_cout, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      bus.req_valid = '0;
      rst_n = 1'b1;
      tick();

      // Single op and carry-wrap cases
      single_op("t1", 0, 64'd5, 64'd200, 1'b0, 64'd205, 1'b0);
      single_op("t2a", 0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, 64'd0, 1'b1);
      single_op("t2b", 2, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1,
                64'hFFFF_FFFF_FFFF_FFFF, 1'b1);

      // Contention among req0..2 from a fresh pointer
      do_reset();
      set_ops(0, 64'd1, 64'd2, 1'b0);
      set_ops(1, 64'd10, 64'd20, 1'b0);
      set_ops(2, 64'd100, 64'd200, 1'b0);
      for (int c = 0; c <= 10; c++) begin
         bus.req_valid = (c < 6) ? 4'b0111 : 4'b0000;
         #1;
         if (c < 6) check($sformatf("t3_gnt%0d", c), bus.req_ready, exp_gnt3[c]);
         if (c >= 4 && c < 10) begin
            check($sformatf("t3_vld%0d", c), bus.rsp_valid, 1'b1);
            check($sformatf("t3_id%0d", c), bus.rsp_id, exp_id3[c-4]);
            check($sformatf("t3_sum%0d", c), bus.rsp_sum, exp_sum3[c-4]);
         end else begin
            check($sformatf("t3_novld%0d", c), bus.rsp_valid, 1'b0);
         end
         tick();
      end

      // Full-throughput stream from req3 alone
      for (int c = 0; c <= 20; c++) begin
         if (c < 16) begin
            bus.req_valid = 4'b1000;
            set_ops(3, 64'(c), 64'(1000 + c), 1'b0);
         end else begin
            bus.req_valid = '0;
         end
         #1;
         if (c < 16) check($sformatf("t4_gnt%0d", c), bus.req_ready, 4'b1000);
         if (c >= 4 && c < 20) begin
            check($sformatf("t4_vld%0d", c), bus.rsp_valid, 1'b1);
            check($sformatf("t4_id%0d", c), bus.rsp_id, 3);
            check($sformatf("t4_sum%0d", c), bus.rsp_sum, 64'(1000 + 2 * (c - 4)));
         end else begin
            check($sformatf("t4_novld%0d", c), bus.rsp_valid, 1'b0);
         end
         tick();
      end

      // Reset with three ops in flight; pointer is left at 2 beforehand
      for (int c = 0; c < 3; c++) begin
         bus.req_valid = 4'b0110;
         #1;
         check($sformatf("t5_gnt%0d", c), bus.req_ready, exp_gnt5[c]);
         tick();
      end
      rst_n = 1'b0;
      #1;
      check("t5_busy_rst", bus.busy, 1'b0);
      check("t5_vld_rst", bus.rsp_valid, 1'b0);
      check("t5_add_a_rst", bus.add_a, 64'd0);
      check("t5_ready_rst", bus.req_ready, 4'b0000);
      tick();
      rst_n = 1'b1;
      bus.req_valid = '0;
      for (int c = 0; c < 5; c++) begin
         #1;
         check($sformatf("t5_discard%0d", c), bus.rsp_valid, 1'b0);
         tick();
      end
      bus.req_valid = 4'b0110;
      #1;
      check("t5_first_gnt", bus.req_ready, 4'b0010);
      tick();
      bus.req_valid = '0;

      // Sparse requesters with the pointer at 2
      do_reset();
      single_op("t6_setup", 1, 64'd11, 64'd22, 1'b0, 64'd33, 1'b0);
      set_ops(1, 64'd11, 64'd22, 1'b0);
      set_ops(3, 64'd33, 64'd44, 1'b0);
      for (int c = 0; c <= 8; c++) begin
         bus.req_valid = (c < 3) ? 4'b1010 : 4'b0000;
         #1;
         if (c < 3) check($sformatf("t6_gnt%0d", c), bus.req_ready, exp_gnt6[c]);
         if (c >= 4 && c < 7) begin
            check($sformatf("t6_vld%0d", c), bus.rsp_valid, 1'b1);
            check($sformatf("t6_id%0d", c), bus.rsp_id, exp_id6[c-4]);
            check($sformatf("t6_sum%0d", c), bus.rsp_sum, exp_sum6[c-4]);
         end else begin
            check($sformatf("t6_novld%0d", c), bus.rsp_valid, 1'b0);
         end
         tick();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
